led_matrix_scanner: RTL and testbench

//   Parametrised, double-buffered row-scan driver for a common-row RGB LED matrix.
//   - Time-multiplexes one active-low row sink at a time.
//   - Adds dead-time blanking between rows to stop ghosting.
//   - Global PWM brightness is applied within each row's on-window.
//   - Frame images come from the game logic and are latched into a shadow buffer only at frame boundaries, so no tearing.

---
 rtl/led_matrix_scanner.sv | 167 ++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// Double-buffered row-scan driver for a common-row RGB LED matrix.
// Each row gets BLANK all-off cycles followed by a DWELL-cycle on-window.
// Global PWM brightness gates the column drivers inside the on-window.
// A new image is latched into the shadow buffer only at the frame boundary.
// Optional feature macro: LED_MATRIX_TEST_PATTERN_EN adds a test_mode input.
// When test_mode is high, the shadow buffer is replaced by a red/green checkerboard.
module led_matrix_scanner #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int DWELL    = 1024,
    parameter int BLANK    = 16,
    parameter int PWM_BITS = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [ROWS*COLS-1:0] red_array,
    input  logic [ROWS*COLS-1:0] green_array,
    input  logic [PWM_BITS-1:0]  brightness,
    input  logic                 frame_load,
`ifdef LED_MATRIX_TEST_PATTERN_EN
    input  logic                 test_mode,
`endif
    output logic                 load_ack,
    output logic                 frame_start,
    output logic [COLS-1:0]      red_driver,
    output logic [COLS-1:0]      green_driver,
    output logic [ROWS-1:0]      row_sink
);

    // One phase counter serves both windows, so size it for the longer one.
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int ROW_W   = $clog2(ROWS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [ROW_W-1:0]       row_reg, row_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [PWM_BITS-1:0]    pwm_reg, pwm_next;
    logic [PWM_BITS-1:0]    bright_reg, bright_next;
    logic                   pend_reg, pend_next;
    logic [ROWS*COLS-1:0]   red_shadow_reg, red_shadow_next;
    logic [ROWS*COLS-1:0]   green_shadow_reg, green_shadow_next;

    logic                   frame_boundary;
    logic                   do_load;
    logic                   lit;
    logic [COLS-1:0]        red_row;
    logic [COLS-1:0]        green_row;

    // First BLANK cycle of row 0 is the only point where a new image may land.
    assign frame_boundary = (state_reg == ST_BLANK) && (row_reg == '0) && (cnt_reg == '0);
    // A load request raised in the boundary cycle itself is honoured immediately.
    assign do_load        = frame_boundary && (pend_reg || frame_load);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg        <= ST_BLANK;
            row_reg          <= '0;
            cnt_reg          <= '0;
            pwm_reg          <= '0;
            bright_reg       <= '0;
            pend_reg         <= 1'b0;
            red_shadow_reg   <= '0;
            green_shadow_reg <= '0;
        end else begin
            state_reg        <= state_next;
            row_reg          <= row_next;
            cnt_reg          <= cnt_next;
            pwm_reg          <= pwm_next;
            bright_reg       <= bright_next;
            pend_reg         <= pend_next;
            red_shadow_reg   <= red_shadow_next;
            green_shadow_reg <= green_shadow_next;
        end
    end

    // Next-state logic: BLANK/ON sequencing, row advance and load handshake.
    always_comb begin
        state_next        = state_reg;
        row_next          = row_reg;
        cnt_next          = cnt_reg + 1'b1;
        pwm_next          = pwm_reg;
        bright_next       = bright_reg;
        pend_next         = pend_reg;
        red_shadow_next   = red_shadow_reg;
        green_shadow_next = green_shadow_reg;

        case (state_reg)
            ST_BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next  = ST_ON;
                    cnt_next    = '0;
                    pwm_next    = '0;
                    bright_next = brightness;
                end
            end
            ST_ON: begin
                pwm_next = pwm_reg + 1'b1;
                if (cnt_reg == DWELL_LAST) begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    row_next   = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_BLANK;
                cnt_next   = '0;
            end
        endcase

        if (do_load) begin
            red_shadow_next   = red_array;
            green_shadow_next = green_array;
            pend_next         = 1'b0;
        end else if (frame_load) begin
            pend_next = 1'b1;
        end
    end

`ifdef LED_MATRIX_TEST_PATTERN_EN
    logic [COLS-1:0] checker_row;

    // Pixel (r,c) is red when r and c share parity; green is the complement.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_checker
        assign checker_row[gi] = (row_reg[0] == 1'(gi % 2));
    end

    // Column data source: checkerboard in test mode, else the shadow row.
    always_comb begin
        red_row   = red_shadow_reg[row_reg*COLS +: COLS];
        green_row = green_shadow_reg[row_reg*COLS +: COLS];
        if (test_mode) begin
            red_row   = checker_row;
            green_row = ~checker_row;
        end
    end
`else
    // Column data source: the shadow row currently being scanned.
    always_comb begin
        red_row   = red_shadow_reg[row_reg*COLS +: COLS];
        green_row = green_shadow_reg[row_reg*COLS +: COLS];
    end
`endif

    assign lit = (state_reg == ST_ON) && (pwm_reg < bright_reg);

    // Output decode; pulses are masked while reset is held so that the first
    // frame_start lands on the first cycle with reset_n released.
    always_comb begin
        row_sink     = (state_reg == ST_ON) ? ~(ROWS'(1) << row_reg) : '1;
        red_driver   = lit ? red_row : '0;
        green_driver = lit ? green_row : '0;
        frame_start  = frame_boundary && reset_n;
        load_ack     = do_load && reset_n;
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner (DWELL=16, BLANK=2, ROWS=COLS=8).
// Each frame is checked cycle by cycle against hand-derived row/PWM timing.
// Define LED_MATRIX_TEST_PATTERN_EN to also exercise the checkerboard mode.
module tb_led_matrix_scanner;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DWELL = 16;
    localparam int BLANK = 2;
    localparam int PWM_BITS = 4;
    localparam int ROW_PERIOD = BLANK + DWELL;       // 18
    localparam int FRAME = ROWS * ROW_PERIOD;        // 144

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [ROWS*COLS-1:0] red_array;
    logic [ROWS*COLS-1:0] green_array;
    logic [PWM_BITS-1:0]  brightness;
    logic                 frame_load;
    logic                 test_mode;
    logic                 load_ack;
    logic                 frame_start;
    logic [COLS-1:0]      red_driver;
    logic [COLS-1:0]      green_driver;
    logic [ROWS-1:0]      row_sink;

    int checks = 0;
    int errors = 0;

    // Per-frame stimulus options, -1 = unused.
    int opt_load_at;
    int opt_load2_at;
    int opt_scramble_at;
    int opt_stop_at;
    logic [63:0] opt_new_r;
    logic [63:0] opt_new_g;

    localparam logic [63:0] IMG1_R = 64'h0F1E2D3C4B5A69A5;
    localparam logic [63:0] IMG1_G = 64'h123456789ABCDEF0;
    localparam logic [63:0] IMG2_R = 64'h1122334455667781;
    localparam logic [63:0] IMG2_G = 64'h8877665544332218;
    localparam logic [63:0] JUNK_R = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] JUNK_G = 64'h0BADC0DE5EED1234;

    int lit0;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK), .PWM_BITS(PWM_BITS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .red_array    (red_array),
        .green_array  (green_array),
        .brightness   (brightness),
        .frame_load   (frame_load),
`ifdef LED_MATRIX_TEST_PATTERN_EN
        .test_mode    (test_mode),
`endif
        .load_ack     (load_ack),
        .frame_start  (frame_start),
        .red_driver   (red_driver),
        .green_driver (green_driver),
        .row_sink     (row_sink)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_opts();
        opt_load_at     = -1;
        opt_load2_at    = -1;
        opt_scramble_at = -1;
        opt_stop_at     = -1;
        opt_new_r       = '0;
        opt_new_g       = '0;
    endtask

    // Entered at posedge+1 of frame cycle 0; leaves at posedge+1 of the next
    // frame's cycle 0 (or of cycle opt_stop_at). Returns lit cycles in row 0.
    task automatic run_frame(input int fno, input logic [63:0] exp_r, input logic [63:0] exp_g,
                             input logic [PWM_BITS-1:0] b, input logic exp_ack, output int lit_row0);
        int row, p, pwm;
        logic lit;
        logic [7:0] e_sink, e_red, e_grn;
        lit_row0 = 0;
        brightness = b;
        for (int c = 0; c < FRAME; c++) begin
            if (c == opt_stop_at) break;
            frame_load = 1'b0;
            if (c == opt_load_at || c == opt_load2_at) begin
                red_array   = opt_new_r;
                green_array = opt_new_g;
                frame_load  = 1'b1;
            end
            if (c == opt_scramble_at) begin
                red_array   = JUNK_R;
                green_array = JUNK_G;
            end
            #1;
            row = c / ROW_PERIOD;
            p   = c % ROW_PERIOD;
            pwm = p - BLANK;
            lit = (p >= BLANK) && (pwm < int'(b));
            e_sink = (p < BLANK) ? 8'hFF : ~(8'h01 << row);
            e_red  = lit ? exp_r[row*8 +: 8] : 8'h00;
            e_grn  = lit ? exp_g[row*8 +: 8] : 8'h00;
            check_eq($sformatf("f%0d c%0d row_sink", fno, c), 64'(row_sink), 64'(e_sink));
            check_eq($sformatf("f%0d c%0d red", fno, c), 64'(red_driver), 64'(e_red));
            check_eq($sformatf("f%0d c%0d green", fno, c), 64'(green_driver), 64'(e_grn));
            check_eq($sformatf("f%0d c%0d frame_start", fno, c), 64'(frame_start), 64'(c == 0));
            check_eq($sformatf("f%0d c%0d load_ack", fno, c), 64'(load_ack),
                     64'((c == 0) ? exp_ack : 1'b0));
            if (row == 0 && (red_driver != 0 || green_driver != 0)) lit_row0++;
            @(posedge clock);
            #1;
        end
        frame_load = 1'b0;
        $display("frame %0d: bright=%0d ack=%0d row0_lit=%0d", fno, b, exp_ack, lit_row0);
    endtask

    initial begin
        reset_n     = 1'b0;
        red_array   = '0;
        green_array = '0;
        brightness  = '0;
        frame_load  = 1'b0;
        test_mode   = 1'b0;
        clear_opts();

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check_eq($sformatf("rst%0d row_sink", i), 64'(row_sink), 64'hFF);
            check_eq($sformatf("rst%0d red", i), 64'(red_driver), 64'h0);
            check_eq($sformatf("rst%0d green", i), 64'(green_driver), 64'h0);
            check_eq($sformatf("rst%0d load_ack", i), 64'(load_ack), 64'h0);
            check_eq($sformatf("rst%0d frame_start", i), 64'(frame_start), 64'h0);
        end
        reset_n = 1'b1;

        // Frame 1: load requested in the frame_start cycle itself, full brightness.
        clear_opts();
        opt_load_at = 0; opt_new_r = IMG1_R; opt_new_g = IMG1_G;
        run_frame(1, IMG1_R, IMG1_G, 4'd15, 1'b1, lit0);
        check_eq("f1 row0 lit count", 64'(lit0), 64'd15);

        // Frame 2: brightness 0 keeps drivers dark while rows still scan.
        clear_opts();
        run_frame(2, IMG1_R, IMG1_G, 4'd0, 1'b0, lit0);
        check_eq("f2 row0 lit count", 64'(lit0), 64'd0);

        // Frame 3: brightness 4, arrays change mid-frame without a load.
        clear_opts();
        opt_scramble_at = 50;
        run_frame(3, IMG1_R, IMG1_G, 4'd4, 1'b0, lit0);
        check_eq("f3 row0 lit count", 64'(lit0), 64'd4);

        // Frame 4: load requested mid row 3, then again (absorbed); old image stays.
        clear_opts();
        opt_load_at = 59; opt_load2_at = 99; opt_new_r = IMG2_R; opt_new_g = IMG2_G;
        run_frame(4, IMG1_R, IMG1_G, 4'd15, 1'b0, lit0);

        // Frame 5: pending load lands at frame_start; later array changes ignored.
        clear_opts();
        opt_scramble_at = 10;
        run_frame(5, IMG2_R, IMG2_G, 4'd15, 1'b1, lit0);
        check_eq("f5 row0 lit count", 64'(lit0), 64'd15);

        // Frame 6: no further load, a single load happened for the two requests.
        clear_opts();
        run_frame(6, IMG2_R, IMG2_G, 4'd15, 1'b0, lit0);

        // Frame 7: pend a load, then reset in the middle of row 5's on-window.
        clear_opts();
        opt_load_at = 20; opt_new_r = JUNK_R; opt_new_g = JUNK_G; opt_stop_at = 97;
        run_frame(7, IMG2_R, IMG2_G, 4'd15, 1'b0, lit0);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_eq("midrst row_sink", 64'(row_sink), 64'hFF);
        check_eq("midrst red", 64'(red_driver), 64'h0);
        check_eq("midrst green", 64'(green_driver), 64'h0);
        check_eq("midrst load_ack", 64'(load_ack), 64'h0);
        check_eq("midrst frame_start", 64'(frame_start), 64'h0);
        reset_n = 1'b1;

        // Frame 8: shadow cleared and pending load dropped, scan restarts at row 0.
        clear_opts();
        run_frame(8, 64'h0, 64'h0, 4'd15, 1'b0, lit0);
        check_eq("f8 row0 lit count", 64'(lit0), 64'd0);

`ifdef LED_MATRIX_TEST_PATTERN_EN
        // Frame 9: checkerboard overrides the (empty) shadow buffer.
        clear_opts();
        test_mode = 1'b1;
        run_frame(9, 64'hAA55AA55AA55AA55, 64'h55AA55AA55AA55AA, 4'd15, 1'b0, lit0);
        check_eq("f9 row0 lit count", 64'(lit0), 64'd15);
        test_mode = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
